adder_sched: RTL and testbench

Two-requester scheduler for the 8-bit registered adder datapath (MyTopLevel). It arbitrates round-robin between two operand streams using valid/ready handshakes, and issues at most one operand pair per cycle to the adder. A tag pipeline routes each adder result back to the requester that issued it. It also sequences the adder's post-reset hold and keeps per-requester completion counts.

---
 rtl/adder_sched_if.sv | 36 +++
 rtl/adder_sched.sv | 107 ++++++++++
 tb/tb_adder_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_sched_if.sv
// Handshake, response and adder-datapath signals of the two-requester adder scheduler.
// slave = scheduler side; master = requesters plus the adder datapath.
interface adder_sched_if #(
    parameter int unsigned DATA_W = 8
);
    logic              req0_valid_i;
    logic              req1_valid_i;
    logic              req0_ready_o;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic              rsp0_valid_o;
    logic              rsp1_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic [DATA_W-1:0] dp_a_o;
    logic [DATA_W-1:0] dp_b_o;
    logic              dp_reset_o;
    logic [DATA_W-1:0] dp_x_i;
    logic              init_done_o;
    logic [15:0]       cnt0_o;
    logic [15:0]       cnt1_o;

    modport slave (
        input  req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i, dp_x_i,
        output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_data_o,
               dp_a_o, dp_b_o, dp_reset_o, init_done_o, cnt0_o, cnt1_o
    );

    modport master (
        output req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i, dp_x_i,
        input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_data_o,
               dp_a_o, dp_b_o, dp_reset_o, init_done_o, cnt0_o, cnt1_o
    );
endinterface

// File: rtl/adder_sched.sv
// Round-robin scheduler feeding a registered adder; a tag pipeline steers each sum back
// to its requester. Also sequences the adder's post-reset hold and counts completions.
module adder_sched #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned RST_CYC = 10
) (
    input logic         clk_i,
    input logic         reset_ni,
    adder_sched_if.slave bus
);
    localparam int unsigned Depth = ADD_LAT + 1;
    localparam int unsigned CntW  = $clog2(RST_CYC + 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   init_cnt_q;
    logic              dp_reset_q;
    logic              init_done_q;
    logic              ptr_q;
    logic [DATA_W-1:0] dp_a_q;
    logic [DATA_W-1:0] dp_b_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp0_q;
    logic              rsp1_q;
    logic [15:0]       cnt0_q;
    logic [15:0]       cnt1_q;
    logic [Depth-1:0]  tag_vld_q;
    logic [Depth-1:0]  tag_id_q;
    logic              grant0;
    logic              grant1;

    // Pointer holds the last served requester; on a tie the other one wins.
    always_comb begin
        grant0 = init_done_q & bus.req0_valid_i & (~bus.req1_valid_i | ptr_q);
        grant1 = init_done_q & bus.req1_valid_i & (~bus.req0_valid_i | ~ptr_q);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            dp_reset_q  <= 1'b1;
            init_done_q <= 1'b0;
            ptr_q       <= 1'b1;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_data_q  <= '0;
            rsp0_q      <= 1'b0;
            rsp1_q      <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (init_cnt_q == CntW'(RST_CYC - 1)) begin
                        state_q     <= StRun;
                        dp_reset_q  <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                end
            endcase

            // Grant implies valid, so a grant is a transfer.
            if (grant0 | grant1) begin
                dp_a_q <= grant1 ? bus.req1_a_i : bus.req0_a_i;
                dp_b_q <= grant1 ? bus.req1_b_i : bus.req0_b_i;
                ptr_q  <= grant1;
            end

            tag_vld_q <= {tag_vld_q[Depth-2:0], grant0 | grant1};
            tag_id_q  <= {tag_id_q[Depth-2:0], grant1};

            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            if (tag_vld_q[Depth-1]) begin
                rsp_data_q <= bus.dp_x_i;
                if (tag_id_q[Depth-1]) begin
                    rsp1_q <= 1'b1;
                    if (cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
                end else begin
                    rsp0_q <= 1'b1;
                    if (cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
                end
            end
        end
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.rsp0_valid_o = rsp0_q;
    assign bus.rsp1_valid_o = rsp1_q;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.dp_a_o       = dp_a_q;
    assign bus.dp_b_o       = dp_b_q;
    assign bus.dp_reset_o   = dp_reset_q;
    assign bus.init_done_o  = init_done_q;
    assign bus.cnt0_o       = cnt0_q;
    assign bus.cnt1_o       = cnt1_q;
endmodule

// File: tb/tb_adder_sched.sv
// Randomized and directed bench for adder_sched: an adder model drives dp_x_i and a
// queue-based scoreboard checks each response against the sum of the accepted operands.
module tb_adder_sched;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADD_LAT = 1;
    localparam int unsigned RST_CYC = 10;

    logic clk_i = 1'b0;
    logic reset_ni;
    always #5 clk_i = ~clk_i;

    adder_sched_if #(.DATA_W(DATA_W)) bus ();

    adder_sched #(.DATA_W(DATA_W), .ADD_LAT(ADD_LAT), .RST_CYC(RST_CYC)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .bus     (bus)
    );

    // Registered adder with ADD_LAT cycles of latency.
    logic [DATA_W-1:0] add_pipe [ADD_LAT];
    always @(posedge clk_i) begin
        add_pipe[0] <= bus.dp_reset_o ? '0 : DATA_W'(bus.dp_a_o + bus.dp_b_o);
        for (int i = 1; i < int'(ADD_LAT); i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign bus.dp_x_i = add_pipe[ADD_LAT-1];

    typedef struct {
        bit     id;
        int     data;
        longint cyc;
    } ent_t;

    ent_t   sb_q [$];
    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    int     edges_m;
    bit     ptr_m;
    bit     pend0 = 0;
    bit     pend1 = 0;
    int     cnt_m0 = 0;
    int     cnt_m1 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference state: edges since reset release and the last served requester.
    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            edges_m <= 0;
            ptr_m   <= 1'b1;
        end else begin
            if (edges_m < int'(RST_CYC)) edges_m <= edges_m + 1;
            if (pend0) ptr_m <= 1'b0;
            else if (pend1) ptr_m <= 1'b1;
        end
    end

    // Monitor and scoreboard, sampling mid-cycle.
    always @(negedge clk_i) begin
        bit   done_m;
        bit   er0;
        bit   er1;
        ent_t e;
        done_m = (edges_m >= int'(RST_CYC));
        if (!reset_ni) begin
            sb_q.delete();
            cnt_m0 = 0;
            cnt_m1 = 0;
            check("reset_dp", {bus.dp_a_o, bus.dp_b_o, bus.rsp_data_o}, 0);
            check("reset_rsp", {bus.rsp1_valid_o, bus.rsp0_valid_o}, 0);
        end
        er0 = done_m && bus.req0_valid_i && (!bus.req1_valid_i || ptr_m);
        er1 = done_m && bus.req1_valid_i && (!bus.req0_valid_i || !ptr_m);
        check("ready", {bus.req1_ready_o, bus.req0_ready_o}, {er1, er0});
        check("init", {bus.dp_reset_o, bus.init_done_o}, {!done_m, done_m});
        if (bus.rsp0_valid_o || bus.rsp1_valid_o) begin
            check("one_rsp", bus.rsp0_valid_o & bus.rsp1_valid_o, 0);
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_id", {bus.rsp1_valid_o, bus.rsp0_valid_o}, e.id ? 2 : 1);
                check("rsp_data", bus.rsp_data_o, e.data);
                check("rsp_latency", cyc - e.cyc, ADD_LAT + 2);
                if (e.id) cnt_m1 = (cnt_m1 < 65535) ? cnt_m1 + 1 : 65535;
                else      cnt_m0 = (cnt_m0 < 65535) ? cnt_m0 + 1 : 65535;
            end
        end
        check("cnt", {bus.cnt1_o, bus.cnt0_o}, {cnt_m1[15:0], cnt_m0[15:0]});
        pend0 = reset_ni && bus.req0_valid_i && bus.req0_ready_o;
        pend1 = reset_ni && bus.req1_valid_i && bus.req1_ready_o;
        if (pend0) sb_q.push_back('{1'b0, (int'(bus.req0_a_i) + int'(bus.req0_b_i)) % 256, cyc});
        if (pend1) sb_q.push_back('{1'b1, (int'(bus.req1_a_i) + int'(bus.req1_b_i)) % 256, cyc});
    end

    // Hold the given inputs for one cycle; returns at posedge+1.
    task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1);
        bus.req0_valid_i = v0;
        bus.req0_a_i     = a0;
        bus.req0_b_i     = b0;
        bus.req1_valid_i = v1;
        bus.req1_a_i     = a1;
        bus.req1_b_i     = b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic do_reset(input int n);
        reset_ni = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
    endtask

    initial begin
        int n;
        reset_ni = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.req0_a_i = '0;
        bus.req0_b_i = '0;
        bus.req1_a_i = '0;
        bus.req1_b_i = '0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset/init with both requesters already valid.
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        do_reset(3);
        n = 0;
        while (!(bus.req0_ready_o || bus.req1_ready_o) && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("init_cycles", n, RST_CYC);
        check("first_grant", {bus.req1_ready_o, bus.req0_ready_o}, 1);
        repeat (4) step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom));
        idle(6);

        // Single stream from req0, including carry wrap.
        do_reset(2);
        idle(RST_CYC);
        step(1'b1, 8'd3, 8'd4, 1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd250, 8'd10, 1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd255, 8'd1, 1'b0, 8'd0, 8'd0);
        idle(6);
        check("single_cnt", {bus.cnt1_o, bus.cnt0_o}, {16'd0, 16'd3});

        // Contention: strict alternation.
        do_reset(2);
        idle(RST_CYC);
        repeat (20) step(1'b1, 8'd1, 8'd1, 1'b1, 8'd2, 8'd2);
        idle(6);
        check("contend_cnt", {bus.cnt1_o, bus.cnt0_o}, {16'd10, 16'd10});

        // Pointer memory: after a req1 transfer, req0 wins the tie.
        do_reset(2);
        idle(RST_CYC);
        step(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'd6);
        bus.req0_valid_i = 1'b1;
        #1;
        check("ptr_memory", {bus.req1_ready_o, bus.req0_ready_o}, 1);
        repeat (3) step(1'b1, 8'd7, 8'd8, 1'b1, 8'd9, 8'd10);
        idle(6);

        // Reset while two transfers are in flight.
        do_reset(2);
        idle(RST_CYC);
        step(1'b1, 8'd11, 8'd12, 1'b1, 8'd13, 8'd14);
        step(1'b1, 8'd11, 8'd12, 1'b1, 8'd13, 8'd14);
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        reset_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("midrst_cnt", {bus.cnt1_o, bus.cnt0_o}, 0);
        check("midrst_dp_reset", bus.dp_reset_o, 1);
        reset_ni = 1'b1;
        idle(RST_CYC + 4);
        check("midrst_reinit", bus.init_done_o, 1);

        // Random traffic.
        repeat (3000) step(1'($urandom), 8'($urandom), 8'($urandom),
                           1'($urandom), 8'($urandom), 8'($urandom));
        idle(6);

        // Saturation of the req1 counter.
        do_reset(2);
        idle(RST_CYC);
        repeat (65540) step(1'b0, 8'd0, 8'd0, 1'b1, 8'($urandom), 8'($urandom));
        idle(6);
        check("sat_cnt", {bus.cnt1_o, bus.cnt0_o}, {16'hFFFF, 16'd0});
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
